// File: rtl/mem_responder.sv
// Word-organised memory responder for the CPU memory bus.
// Captures one request, waits WAIT_STATES cycles, then answers with a ready pulse.
module mem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic        iClk,
  input  logic        nRst,
  input  logic [31:0] iMemAddr,
  input  logic [31:0] iMemData,
  input  logic        iMemRead,
  input  logic        iMemWrite,
  output logic [31:0] oMemData,
  output logic        oMemReady,
  output logic        oMemErr
);

  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [3:0]  cnt;
  logic [3:0]  cnt_nx;
  logic [31:0] cap_addr;
  logic [31:0] cap_data;
  logic        cap_rd;
  logic        cap_wr;
  logic [31:0] offset;
  logic [AW-1:0] idx;
  logic        take;
  logic        reject;
  logic        rd_ok;
  logic        wr_ok;

  logic [31:0] mem [DEPTH_WORDS];

  assign take   = (state == IDLE) && (iMemRead || iMemWrite);
  assign offset = cap_addr - BASE_ADDR;
  assign idx    = offset[AW+1:2];

  // Range test uses the raw address too, so addresses below the base never wrap in.
  assign reject = (cap_addr[1:0] != 2'b00)
               || (cap_addr < BASE_ADDR)
               || (offset >= SPAN)
               || (cap_rd && cap_wr);

  assign rd_ok = (state == RESP) && cap_rd && !reject;
  assign wr_ok = (state == RESP) && cap_wr && !reject;

  // WAIT always lasts WAIT_STATES+1 cycles so ready lands at k+2+WAIT_STATES.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (take) begin
          state_nx = WAIT;
          cnt_nx   = 4'(WAIT_STATES);
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_nx = RESP;
        else             cnt_nx   = cnt - 4'd1;
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      cap_addr <= 32'd0;
      cap_data <= 32'd0;
      cap_rd   <= 1'b0;
      cap_wr   <= 1'b0;
    end else if (take) begin
      cap_addr <= iMemAddr;
      cap_data <= iMemData;
      cap_rd   <= iMemRead;
      cap_wr   <= iMemWrite;
    end
  end

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      oMemData  <= 32'd0;
      oMemReady <= 1'b0;
      oMemErr   <= 1'b0;
    end else begin
      oMemReady <= (state == RESP);
      oMemErr   <= (state == RESP) && reject;
      if (rd_ok) oMemData <= mem[idx];
    end
  end

  always_ff @(posedge iClk) begin
    if (wr_ok) mem[idx] <= cap_data;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three instances cover
// WAIT_STATES=1/0 and two depths.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [31:0] rdata [3];
  logic        rd    [3];
  logic        wr    [3];
  logic        ready [3];
  logic        err   [3];

  int n_cmp = 0;
  int n_bad = 0;
  int lat_exp [3] = '{3, 3, 2};

  always #5 clk = ~clk;

  mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(1)) u_a (
    .iClk(clk), .nRst(rst_n),
    .iMemAddr(addr[0]), .iMemData(wdata[0]),
    .iMemRead(rd[0]), .iMemWrite(wr[0]),
    .oMemData(rdata[0]), .oMemReady(ready[0]), .oMemErr(err[0])
  );

  mem_responder #(.DEPTH_WORDS(2048), .BASE_ADDR(32'h0), .WAIT_STATES(1)) u_b (
    .iClk(clk), .nRst(rst_n),
    .iMemAddr(addr[1]), .iMemData(wdata[1]),
    .iMemRead(rd[1]), .iMemWrite(wr[1]),
    .oMemData(rdata[1]), .oMemReady(ready[1]), .oMemErr(err[1])
  );

  mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u_c (
    .iClk(clk), .nRst(rst_n),
    .iMemAddr(addr[2]), .iMemData(wdata[2]),
    .iMemRead(rd[2]), .iMemWrite(wr[2]),
    .oMemData(rdata[2]), .oMemReady(ready[2]), .oMemErr(err[2])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Drive a request now; edge k is the next rising edge.
  task automatic op(input string tag, input int u,
                    input logic r, input logic w,
                    input logic [31:0] a, input logic [31:0] d,
                    input logic e_exp, output logic [31:0] q);
    int   lat;
    logic pre;
    addr[u]  = a;
    wdata[u] = d;
    rd[u]    = r;
    wr[u]    = w;
    @(posedge clk);
    #1;
    pre = ready[u];
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (lat < 40 && ready[u] !== 1'b1);
    rd[u] = 1'b0;
    wr[u] = 1'b0;
    q = rdata[u];
    chk({tag, "_pre"}, pre, 1'b0);
    chk({tag, "_lat"}, lat, lat_exp[u]);
    chk({tag, "_err"}, err[u], e_exp);
  endtask

  initial begin
    logic [31:0] q;
    int          n;
    rst_n = 1'b0;
    for (int u = 0; u < 3; u++) begin
      addr[u] = 32'd0; wdata[u] = 32'd0; rd[u] = 1'b0; wr[u] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int u = 0; u < 3; u++) begin
      chk($sformatf("rst_data%0d", u), rdata[u], 32'd0);
      chk($sformatf("rst_rdy%0d", u), ready[u], 1'b0);
      chk($sformatf("rst_err%0d", u), err[u], 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset aborts a pending write
    op("t1_w", 0, 1'b0, 1'b1, 32'h40, 32'h1234_5678, 1'b0, q);
    op("t1_r", 0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, q);
    chk("t1_rd", q, 32'h1234_5678);
    addr[0] = 32'h40; wdata[0] = 32'hDEAD_BEEF; wr[0] = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t1_rst_data", rdata[0], 32'd0);
    chk("t1_rst_rdy", ready[0], 1'b0);
    chk("t1_rst_err", err[0], 1'b0);
    wr[0] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    op("t1_r2", 0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, q);
    chk("t1_keep", q, 32'h1234_5678);

    // WAIT_STATES=1 write then read
    op("t2_w", 1, 1'b0, 1'b1, 32'h1000, 32'h0000_0009, 1'b0, q);
    op("t2_r", 1, 1'b1, 1'b0, 32'h1000, 32'h0, 1'b0, q);
    chk("t2_rd", q, 32'h9);

    // Misaligned accesses
    op("t4_r", 1, 1'b1, 1'b0, 32'h1002, 32'h0, 1'b1, q);
    chk("t4_hold", q, 32'h9);
    op("t4_w", 1, 1'b0, 1'b1, 32'h1001, 32'h77, 1'b1, q);
    chk("t4_hold2", q, 32'h9);
    op("t4_r2", 1, 1'b1, 1'b0, 32'h1000, 32'h0, 1'b0, q);
    chk("t4_ram", q, 32'h9);

    // Strobe dropped after capture still completes the write
    addr[1] = 32'h1004; wdata[1] = 32'h5; wr[1] = 1'b1;
    @(posedge clk);
    #1;
    wr[1] = 1'b0;
    n = 0;
    while (n < 20 && ready[1] !== 1'b1) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drop_lat", n, 3);
    op("drop_r", 1, 1'b1, 1'b0, 32'h1004, 32'h0, 1'b0, q);
    chk("drop_rd", q, 32'h5);

    // WAIT_STATES=0 back-to-back
    op("t3_w4", 2, 1'b0, 1'b1, 32'h4, 32'h2, 1'b0, q);
    op("t3_w8", 2, 1'b0, 1'b1, 32'h8, 32'h3, 1'b0, q);
    op("t3_r4", 2, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0, q);
    chk("t3_rd4", q, 32'h2);
    op("t3_r8", 2, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0, q);
    chk("t3_rd8", q, 32'h3);

    // Range limit at DEPTH=1024
    op("t5_oor", 0, 1'b1, 1'b0, 32'h1000, 32'h0, 1'b1, q);
    chk("t5_hold", q, 32'h1234_5678);
    op("t5_w", 0, 1'b0, 1'b1, 32'hFFC, 32'hA5A5_0FFC, 1'b0, q);
    op("t5_r", 0, 1'b1, 1'b0, 32'hFFC, 32'h0, 1'b0, q);
    chk("t5_rd", q, 32'hA5A5_0FFC);

    // Read and write together
    op("t6_w", 0, 1'b0, 1'b1, 32'h0, 32'h1111_1111, 1'b0, q);
    op("t6_rw", 0, 1'b1, 1'b1, 32'h0, 32'h2222_2222, 1'b1, q);
    op("t6_r", 0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, q);
    chk("t6_rd", q, 32'h1111_1111);

    @(posedge clk);
    #1;
    chk("final_rdy", ready[0], 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
